// File: rtl/lb_arbiter_if.sv
// Signal bundle for lb_arbiter: host port, sequencer req/ack port and cryomodule bus side.
// The slave modport is the arbiter's view; the master modport is the view of whatever drives it.
interface lb_arbiter_if #(
  parameter int AW       = 24,
  parameter int DW       = 32,
  parameter int STARVE_W = 16
) ();
  logic                h_strobe;
  logic                h_write;
  logic [AW-1:0]       h_addr;
  logic [DW-1:0]       h_wdata;
  logic [DW-1:0]       h_rdata;
  logic                h_rvalid;

  logic                s_req;
  logic                s_write;
  logic [AW-1:0]       s_addr;
  logic [DW-1:0]       s_wdata;
  logic                s_ack;
  logic [DW-1:0]       s_rdata;
  logic                s_rvalid;
  logic [STARVE_W-1:0] s_starve_cnt;

  logic [AW-1:0]       bus_addr;
  logic [DW-1:0]       bus_wdata;
  logic                bus_write;
  logic                bus_read;
  logic [DW-1:0]       bus_din;

  modport slave (
    input  h_strobe, h_write, h_addr, h_wdata,
    output h_rdata, h_rvalid,
    input  s_req, s_write, s_addr, s_wdata,
    output s_ack, s_rdata, s_rvalid, s_starve_cnt,
    output bus_addr, bus_wdata, bus_write, bus_read,
    input  bus_din
  );

  modport master (
    output h_strobe, h_write, h_addr, h_wdata,
    input  h_rdata, h_rvalid,
    output s_req, s_write, s_addr, s_wdata,
    input  s_ack, s_rdata, s_rvalid, s_starve_cnt,
    input  bus_addr, bus_wdata, bus_write, bus_read,
    output bus_din
  );
endinterface

// File: rtl/lb_arbiter.sv
// Two-master local-bus arbiter: host has strict priority, sequencer uses req/ack, and read data is
// routed back to its issuer by an owner tag pipeline. Optional stall counter: LB_ARB_STARVE_CNT_EN.
module lb_arbiter #(
  parameter int AW         = 24,
  parameter int DW         = 32,
  parameter int READ_DELAY = 3,
  parameter int STARVE_W   = 16
) (
  input  logic        lb_clk,
  input  logic        lb_rst_n,
  lb_arbiter_if.slave lb
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOST = 2'd1,
    SEQ  = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [AW-1:0]              addr_q, addr_d;
  logic [DW-1:0]              wdata_q, wdata_d;
  logic                       write_q, write_d;
  logic [READ_DELAY-1:0][1:0] tag_q, tag_d;
  logic [DW-1:0]              h_rdata_q, h_rdata_d;
  logic [DW-1:0]              s_rdata_q, s_rdata_d;
  logic                       h_rvalid_q, h_rvalid_d;
  logic                       s_rvalid_q, s_rvalid_d;
  logic                       bus_read_c, bus_write_c, s_ack_c;
  logic [1:0]                 tail;

  // state_q is the issue currently on the bus; state_d is this cycle's selection
  always_ff @(posedge lb_clk) begin
    if (!lb_rst_n) state_q <= IDLE;
    else           state_q <= state_d;
  end

  always_comb begin
    state_d = IDLE;
    if (!lb_rst_n)        state_d = IDLE;
    else if (lb.h_strobe) state_d = HOST;
    else if (lb.s_req)    state_d = SEQ;
  end

  always_comb begin
    s_ack_c     = (state_d == SEQ);
    bus_read_c  = 1'b0;
    bus_write_c = 1'b0;
    if (state_q != IDLE) begin
      bus_write_c = write_q;
      bus_read_c  = ~write_q;
    end
  end

  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    write_d = write_q;
    case (state_d)
      HOST: begin
        addr_d  = lb.h_addr;
        wdata_d = lb.h_wdata;
        write_d = lb.h_write;
      end
      SEQ: begin
        addr_d  = lb.s_addr;
        wdata_d = lb.s_wdata;
        write_d = lb.s_write;
      end
      default: ;
    endcase
  end

  // Tags enter when the read strobe is on the bus, so the tail lines up with valid bus_din
  assign tail = tag_q[READ_DELAY-1];

  always_comb begin
    tag_d      = tag_q << 2;
    tag_d[0]   = {bus_read_c, state_q == SEQ};
    h_rvalid_d = tail[1] & ~tail[0];
    s_rvalid_d = tail[1] & tail[0];
    h_rdata_d  = h_rvalid_d ? lb.bus_din : h_rdata_q;
    s_rdata_d  = s_rvalid_d ? lb.bus_din : s_rdata_q;
  end

  always_ff @(posedge lb_clk) begin
    if (!lb_rst_n) begin
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      tag_q      <= '0;
      h_rdata_q  <= '0;
      s_rdata_q  <= '0;
      h_rvalid_q <= 1'b0;
      s_rvalid_q <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      tag_q      <= tag_d;
      h_rdata_q  <= h_rdata_d;
      s_rdata_q  <= s_rdata_d;
      h_rvalid_q <= h_rvalid_d;
      s_rvalid_q <= s_rvalid_d;
    end
  end

  assign lb.bus_addr  = addr_q;
  assign lb.bus_wdata = wdata_q;
  assign lb.bus_write = bus_write_c;
  assign lb.bus_read  = bus_read_c;
  assign lb.s_ack     = s_ack_c;
  assign lb.h_rdata   = h_rdata_q;
  assign lb.s_rdata   = s_rdata_q;
  assign lb.h_rvalid  = h_rvalid_q;
  assign lb.s_rvalid  = s_rvalid_q;

`ifdef LB_ARB_STARVE_CNT_EN
  logic [STARVE_W-1:0] starve_q, starve_d;

  // Saturating count of cycles the sequencer waited; survives acks, cleared only by reset
  always_comb begin
    starve_d = starve_q;
    if (lb.s_req && !s_ack_c && !(&starve_q)) starve_d = starve_q + STARVE_W'(1);
  end

  always_ff @(posedge lb_clk) begin
    if (!lb_rst_n) starve_q <= '0;
    else           starve_q <= starve_d;
  end

  assign lb.s_starve_cnt = starve_q;
`else
  assign lb.s_starve_cnt = {STARVE_W{1'b0}};
`endif

endmodule

// File: tb/tb_lb_arbiter.sv
// Directed and scoreboard bench for lb_arbiter, with a fixed-latency bus model on bus_din.
// Expected stall count follows LB_ARB_STARVE_CNT_EN.
module tb_lb_arbiter;
  localparam int AW = 24;
  localparam int DW = 32;
  localparam int RD = 3;
  localparam int SW = 16;
`ifdef LB_ARB_STARVE_CNT_EN
  localparam int EXP_STARVE = 20;
`else
  localparam int EXP_STARVE = 0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lb_arbiter_if #(.AW(AW), .DW(DW), .STARVE_W(SW)) lbi ();

  lb_arbiter #(.AW(AW), .DW(DW), .READ_DELAY(RD), .STARVE_W(SW)) dut (
    .lb_clk   (clk),
    .lb_rst_n (rst_n),
    .lb       (lbi)
  );

  int checks = 0;
  int errors = 0;

  // Bus model: each read strobe returns data RD cycles later, from a table or an auto sequence
  int          reads_seen = 0;
  int          resp_base = 0;
  logic        resp_mode = 1'b0;
  logic [31:0] resp_tab [8];
  logic [32:0] bm_pipe [RD] = '{default: '0};
  logic [31:0] bm_data;

  always_comb begin
    bm_data = resp_mode ? resp_tab[3'(reads_seen - resp_base)] : 32'hC000_0000 + 32'(reads_seen);
  end

  always @(posedge clk) begin
    bm_pipe[0] <= {lbi.bus_read, bm_data};
    for (int k = 1; k < RD; k++) bm_pipe[k] <= bm_pipe[k-1];
    if (lbi.bus_read) reads_seen <= reads_seen + 1;
  end

  assign lbi.bus_din = bm_pipe[RD-1][32] ? bm_pipe[RD-1][31:0] : 32'hA5A5_A5A5;

  initial begin
    #3_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    lbi.h_strobe = 1'b0;
    lbi.h_write  = 1'b0;
    lbi.h_addr   = '0;
    lbi.h_wdata  = '0;
    lbi.s_req    = 1'b0;
    lbi.s_write  = 1'b0;
    lbi.s_addr   = '0;
    lbi.s_wdata  = '0;
  endtask

  task automatic do_reset(input int n);
    rst_n = 1'b0;
    idle_inputs();
    repeat (n) tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    @(negedge clk);
    checks++; if (lbi.bus_addr !== 24'h0) begin errors++; $display("[TB] FAIL reset_bus_addr: got %h expected 000000", lbi.bus_addr); end
    checks++; if (lbi.bus_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_bus_wdata: got %h expected 0", lbi.bus_wdata); end
    checks++; if ({lbi.h_rdata, lbi.s_rdata} !== 64'h0) begin errors++; $display("[TB] FAIL reset_rdata: got %h/%h expected 0/0", lbi.h_rdata, lbi.s_rdata); end
    checks++; if ({lbi.bus_write, lbi.bus_read, lbi.s_ack, lbi.h_rvalid, lbi.s_rvalid} !== 5'b0) begin errors++; $display("[TB] FAIL reset_strobes: got %b expected 00000", {lbi.bus_write, lbi.bus_read, lbi.s_ack, lbi.h_rvalid, lbi.s_rvalid}); end
    checks++; if (lbi.s_starve_cnt !== 16'h0) begin errors++; $display("[TB] FAIL reset_starve: got %0d expected 0", lbi.s_starve_cnt); end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_host_read;
    resp_mode   = 1'b1;
    resp_base   = reads_seen;
    resp_tab[0] = 32'hDEAD_BEEF;
    lbi.h_strobe = 1'b1;
    lbi.h_write  = 1'b0;
    lbi.h_addr   = 24'h010040;
    @(negedge clk);
    checks++; if (lbi.s_ack !== 1'b0) begin errors++; $display("[TB] FAIL host_read_ack: got %b expected 0", lbi.s_ack); end
    tick();
    idle_inputs();
    for (int c = 1; c <= 6; c++) begin
      @(negedge clk);
      checks++; if (lbi.bus_read !== (c == 1)) begin errors++; $display("[TB] FAIL host_read_strobe c%0d: got %b expected %b", c, lbi.bus_read, c == 1); end
      checks++; if (lbi.h_rvalid !== (c == 5)) begin errors++; $display("[TB] FAIL host_read_rvalid c%0d: got %b expected %b", c, lbi.h_rvalid, c == 5); end
      checks++; if (lbi.s_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL host_read_s_rvalid c%0d: got %b expected 0", c, lbi.s_rvalid); end
      if (c == 1) begin
        checks++; if (lbi.bus_addr !== 24'h010040) begin errors++; $display("[TB] FAIL host_read_addr: got %h expected 010040", lbi.bus_addr); end
      end
      if (c == 5) begin
        checks++; if (lbi.h_rdata !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL host_read_data: got %h expected deadbeef", lbi.h_rdata); end
      end
      tick();
    end
  endtask

  task automatic test_priority;
    lbi.h_strobe = 1'b1;
    lbi.h_write  = 1'b1;
    lbi.h_addr   = 24'h000020;
    lbi.h_wdata  = 32'hAAAA_5555;
    lbi.s_req    = 1'b1;
    lbi.s_write  = 1'b1;
    lbi.s_addr   = 24'h000010;
    lbi.s_wdata  = 32'h1234_5678;
    @(negedge clk);
    checks++; if (lbi.s_ack !== 1'b0) begin errors++; $display("[TB] FAIL prio_ack_c0: got %b expected 0", lbi.s_ack); end
    tick();
    lbi.h_strobe = 1'b0;
    @(negedge clk);
    checks++; if ({lbi.bus_write, lbi.bus_read} !== 2'b10) begin errors++; $display("[TB] FAIL prio_host_strobe: got %b expected 10", {lbi.bus_write, lbi.bus_read}); end
    checks++; if ({lbi.bus_addr, lbi.bus_wdata} !== {24'h000020, 32'hAAAA_5555}) begin errors++; $display("[TB] FAIL prio_host_cmd: got %h/%h expected 000020/aaaa5555", lbi.bus_addr, lbi.bus_wdata); end
    checks++; if (lbi.s_ack !== 1'b1) begin errors++; $display("[TB] FAIL prio_ack_c1: got %b expected 1", lbi.s_ack); end
    tick();
    lbi.s_req = 1'b0;
    @(negedge clk);
    checks++; if ({lbi.bus_write, lbi.bus_read} !== 2'b10) begin errors++; $display("[TB] FAIL prio_seq_strobe: got %b expected 10", {lbi.bus_write, lbi.bus_read}); end
    checks++; if ({lbi.bus_addr, lbi.bus_wdata} !== {24'h000010, 32'h1234_5678}) begin errors++; $display("[TB] FAIL prio_seq_cmd: got %h/%h expected 000010/12345678", lbi.bus_addr, lbi.bus_wdata); end
    checks++; if (lbi.s_ack !== 1'b0) begin errors++; $display("[TB] FAIL prio_ack_c2: got %b expected 0", lbi.s_ack); end
    tick();
    for (int c = 3; c <= 8; c++) begin
      @(negedge clk);
      checks++; if ({lbi.bus_write, lbi.bus_read, lbi.h_rvalid, lbi.s_rvalid} !== 4'b0) begin errors++; $display("[TB] FAIL prio_idle c%0d: got %b expected 0000", c, {lbi.bus_write, lbi.bus_read, lbi.h_rvalid, lbi.s_rvalid}); end
      checks++; if (lbi.bus_addr !== 24'h000010) begin errors++; $display("[TB] FAIL prio_addr_hold c%0d: got %h expected 000010", c, lbi.bus_addr); end
      tick();
    end
  endtask

  task automatic test_interleave;
    logic [31:0] exp_h, exp_s;
    resp_mode = 1'b1;
    resp_base = reads_seen;
    for (int k = 0; k < 4; k++) resp_tab[k] = 32'(k + 1);
    for (int c = 0; c <= 9; c++) begin
      lbi.h_strobe = (c == 0 || c == 2);
      lbi.h_write  = 1'b0;
      lbi.h_addr   = 24'h000100 + 24'(c);
      lbi.s_req    = (c == 1 || c == 3);
      lbi.s_write  = 1'b0;
      lbi.s_addr   = 24'h000200 + 24'(c);
      @(negedge clk);
      checks++; if (lbi.s_ack !== (c == 1 || c == 3)) begin errors++; $display("[TB] FAIL ilv_ack c%0d: got %b expected %b", c, lbi.s_ack, c == 1 || c == 3); end
      checks++; if (lbi.bus_read !== (c >= 1 && c <= 4)) begin errors++; $display("[TB] FAIL ilv_strobe c%0d: got %b expected %b", c, lbi.bus_read, c >= 1 && c <= 4); end
      checks++; if (lbi.h_rvalid !== (c == 5 || c == 7)) begin errors++; $display("[TB] FAIL ilv_h_rvalid c%0d: got %b expected %b", c, lbi.h_rvalid, c == 5 || c == 7); end
      checks++; if (lbi.s_rvalid !== (c == 6 || c == 8)) begin errors++; $display("[TB] FAIL ilv_s_rvalid c%0d: got %b expected %b", c, lbi.s_rvalid, c == 6 || c == 8); end
      if (c >= 5) begin
        exp_h = (c >= 7) ? 32'd3 : 32'd1;
        checks++; if (lbi.h_rdata !== exp_h) begin errors++; $display("[TB] FAIL ilv_h_rdata c%0d: got %h expected %h", c, lbi.h_rdata, exp_h); end
      end
      if (c >= 6) begin
        exp_s = (c >= 8) ? 32'd4 : 32'd2;
        checks++; if (lbi.s_rdata !== exp_s) begin errors++; $display("[TB] FAIL ilv_s_rdata c%0d: got %h expected %h", c, lbi.s_rdata, exp_s); end
      end
      tick();
    end
  endtask

  task automatic test_reset_drop;
    idle_inputs();
    for (int c = 0; c <= 9; c++) begin
      lbi.s_req   = (c == 0);
      lbi.s_write = 1'b0;
      lbi.s_addr  = 24'h000055;
      rst_n       = (c != 2);
      @(negedge clk);
      if (c == 0) begin
        checks++; if (lbi.s_ack !== 1'b1) begin errors++; $display("[TB] FAIL drop_ack: got %b expected 1", lbi.s_ack); end
      end
      if (c == 1) begin
        checks++; if ({lbi.bus_read, lbi.bus_addr} !== {1'b1, 24'h000055}) begin errors++; $display("[TB] FAIL drop_issue: got %b/%h expected 1/000055", lbi.bus_read, lbi.bus_addr); end
      end
      if (c == 3) begin
        checks++; if ({lbi.bus_addr, lbi.bus_wdata, lbi.h_rdata, lbi.s_rdata} !== '0) begin errors++; $display("[TB] FAIL drop_after_reset_data: got %h/%h/%h/%h expected all 0", lbi.bus_addr, lbi.bus_wdata, lbi.h_rdata, lbi.s_rdata); end
        checks++; if ({lbi.bus_write, lbi.bus_read, lbi.s_ack, lbi.h_rvalid} !== 4'b0) begin errors++; $display("[TB] FAIL drop_after_reset_strobes: got %b expected 0000", {lbi.bus_write, lbi.bus_read, lbi.s_ack, lbi.h_rvalid}); end
        checks++; if (lbi.s_starve_cnt !== 16'h0) begin errors++; $display("[TB] FAIL drop_after_reset_starve: got %0d expected 0", lbi.s_starve_cnt); end
      end
      checks++; if (lbi.s_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL drop_s_rvalid c%0d: got %b expected 0", c, lbi.s_rvalid); end
      tick();
    end
    rst_n = 1'b1;
  endtask

  task automatic test_starve;
    do_reset(2);
    resp_mode   = 1'b1;
    resp_base   = reads_seen;
    resp_tab[0] = 32'h5EC0_0077;
    for (int c = 0; c <= 27; c++) begin
      lbi.h_strobe = (c < 20);
      lbi.h_write  = 1'b1;
      lbi.h_addr   = 24'h000300 + 24'(c);
      lbi.s_req    = (c <= 20);
      lbi.s_write  = 1'b0;
      lbi.s_addr   = 24'h000077;
      @(negedge clk);
      checks++; if (lbi.s_ack !== (c == 20)) begin errors++; $display("[TB] FAIL starve_ack c%0d: got %b expected %b", c, lbi.s_ack, c == 20); end
      if (c == 20 || c == 22) begin
        checks++; if (lbi.s_starve_cnt !== 16'(EXP_STARVE)) begin errors++; $display("[TB] FAIL starve_cnt c%0d: got %0d expected %0d", c, lbi.s_starve_cnt, EXP_STARVE); end
      end
      if (c == 21) begin
        checks++; if ({lbi.bus_read, lbi.bus_addr} !== {1'b1, 24'h000077}) begin errors++; $display("[TB] FAIL starve_seq_issue: got %b/%h expected 1/000077", lbi.bus_read, lbi.bus_addr); end
      end
      checks++; if (lbi.s_rvalid !== (c == 25)) begin errors++; $display("[TB] FAIL starve_s_rvalid c%0d: got %b expected %b", c, lbi.s_rvalid, c == 25); end
      if (c == 25) begin
        checks++; if (lbi.s_rdata !== 32'h5EC0_0077) begin errors++; $display("[TB] FAIL starve_s_rdata: got %h expected 5ec00077", lbi.s_rdata); end
      end
      checks++; if (lbi.h_rvalid !== 1'b0) begin errors++; $display("[TB] FAIL starve_h_rvalid c%0d: got %b expected 0", c, lbi.h_rvalid); end
      tick();
    end
  endtask

  task automatic test_random;
    int          n_cyc;
    int          exp_issue, prev_issue, nread, base, slot;
    logic        prev_write, prev_ack, exp_rd, exp_wr;
    logic [AW-1:0] prev_addr;
    logic [DW-1:0] prev_wdata;
    logic        rv_v [16];
    logic        rv_own [16];
    logic [DW-1:0] rv_data [16];
    n_cyc = 10000;
    do_reset(2);
    idle_inputs();
    repeat (RD + 4) tick();
    resp_mode  = 1'b0;
    base       = reads_seen;
    nread      = 0;
    prev_issue = 0;
    prev_write = 1'b0;
    prev_ack   = 1'b0;
    prev_addr  = '0;
    prev_wdata = '0;
    for (int k = 0; k < 16; k++) begin
      rv_v[k] = 1'b0; rv_own[k] = 1'b0; rv_data[k] = '0;
    end
    for (int i = 0; i < n_cyc + 12; i++) begin
      if (i < n_cyc) begin
        lbi.h_strobe = ($urandom_range(0, 99) < 40);
        lbi.h_write  = 1'($urandom_range(0, 1));
        lbi.h_addr   = AW'($urandom);
        lbi.h_wdata  = $urandom;
        if (!lbi.s_req || prev_ack) begin
          lbi.s_req   = 1'($urandom_range(0, 1));
          lbi.s_write = 1'($urandom_range(0, 1));
          lbi.s_addr  = AW'($urandom);
          lbi.s_wdata = $urandom;
        end
      end else begin
        idle_inputs();
      end
      exp_issue = lbi.h_strobe ? 1 : (lbi.s_req ? 2 : 0);
      @(negedge clk);
      exp_rd = (prev_issue != 0) && !prev_write;
      exp_wr = (prev_issue != 0) && prev_write;
      checks++; if (lbi.s_ack !== (exp_issue == 2)) begin errors++; $display("[TB] FAIL rnd_ack cyc%0d: got %b expected %b", i, lbi.s_ack, exp_issue == 2); end
      checks++; if ({lbi.bus_read, lbi.bus_write} !== {exp_rd, exp_wr}) begin errors++; $display("[TB] FAIL rnd_strobe cyc%0d: got %b expected %b", i, {lbi.bus_read, lbi.bus_write}, {exp_rd, exp_wr}); end
      if (prev_issue != 0) begin
        checks++; if (lbi.bus_addr !== prev_addr) begin errors++; $display("[TB] FAIL rnd_addr cyc%0d: got %h expected %h", i, lbi.bus_addr, prev_addr); end
        if (prev_write) begin
          checks++; if (lbi.bus_wdata !== prev_wdata) begin errors++; $display("[TB] FAIL rnd_wdata cyc%0d: got %h expected %h", i, lbi.bus_wdata, prev_wdata); end
        end
      end
      if (exp_rd) begin
        slot          = (i + RD + 1) % 16;
        rv_v[slot]    = 1'b1;
        rv_own[slot]  = (prev_issue == 2);
        rv_data[slot] = 32'hC000_0000 + 32'(base + nread);
        nread++;
      end
      slot = i % 16;
      checks++; if ({lbi.h_rvalid, lbi.s_rvalid} !== {rv_v[slot] && !rv_own[slot], rv_v[slot] && rv_own[slot]}) begin errors++; $display("[TB] FAIL rnd_rvalid cyc%0d: got %b expected %b", i, {lbi.h_rvalid, lbi.s_rvalid}, {rv_v[slot] && !rv_own[slot], rv_v[slot] && rv_own[slot]}); end
      if (rv_v[slot]) begin
        if (rv_own[slot]) begin
          checks++; if (lbi.s_rdata !== rv_data[slot]) begin errors++; $display("[TB] FAIL rnd_s_rdata cyc%0d: got %h expected %h", i, lbi.s_rdata, rv_data[slot]); end
        end else begin
          checks++; if (lbi.h_rdata !== rv_data[slot]) begin errors++; $display("[TB] FAIL rnd_h_rdata cyc%0d: got %h expected %h", i, lbi.h_rdata, rv_data[slot]); end
        end
      end
      rv_v[slot] = 1'b0;
      prev_issue = exp_issue;
      prev_ack   = (exp_issue == 2);
      if (exp_issue == 1) begin
        prev_write = lbi.h_write; prev_addr = lbi.h_addr; prev_wdata = lbi.h_wdata;
      end else if (exp_issue == 2) begin
        prev_write = lbi.s_write; prev_addr = lbi.s_addr; prev_wdata = lbi.s_wdata;
      end
      tick();
    end
  endtask

  initial begin
    for (int k = 0; k < 8; k++) resp_tab[k] = '0;
    idle_inputs();
    test_reset();
    test_host_read();
    test_priority();
    test_interleave();
    test_reset_drop();
    test_starve();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lb_arbiter.md
# lb_arbiter

Shares the single cryomodule local bus between two masters. Master H is the host path from the Ethernet local-bus bridge: it never stalls and always has priority. Master S is an on-chip sequencer that uses a req/ack handshake. The block also tracks in-flight reads through the bus's fixed read latency and returns each read result only to the master that issued it. It sits between the host local bus and the cryomodule `lb_*` ports, all on `lb_clk`.

## Interface
Parameters:
- `AW`, 24: address width.
- `DW`, 32: data width.
- `READ_DELAY`, 3: fixed cycles from a bus read strobe to valid `bus_din`. Legal range is 1..8.
- `STARVE_W`, 16: width of the starvation counter (configuration option only).

Ports:
- `lb_clk`  in  1  the one clock.
- `lb_rst_n`  in  1  reset: synchronous and active-low.
- `h_strobe`  in  1  host transaction valid this cycle.
- `h_write`  in  1  host write (1) or read (0).
- `h_addr`  in  AW  host address.
- `h_wdata`  in  DW  host write data.
- `h_rdata`  out  DW  read data returned to the host.
- `h_rvalid`  out  1  one-cycle pulse marking valid `h_rdata`.
- `s_req`  in  1  sequencer request, held until `s_ack`.
- `s_write`, `s_addr`, `s_wdata`  in  1/AW/DW  sequencer command. These must be stable while `s_req` is high.
- `s_ack`  out  1  one-cycle pulse: the command was issued on the bus this cycle.
- `s_rdata`  out  DW  read data returned to the sequencer.
- `s_rvalid`  out  1  one-cycle pulse marking valid `s_rdata`.
- `bus_addr`  out  AW  bus address.
- `bus_wdata`  out  DW  bus write data.
- `bus_write`  out  1  single-cycle write strobe.
- `bus_read`  out  1  single-cycle read strobe.
- `bus_din`  in  DW  bus read data.
- `s_starve_cnt`  out  STARVE_W  sequencer stall-cycle count (configuration option only).

## Operation
- Each cycle the arbiter selects at most one issue, combinationally, and registers it onto the bus outputs.
- The host wins whenever `h_strobe` is high.
- The sequencer is issued only when `h_strobe` is low and `s_req` is high. `s_ack` pulses in the cycle the sequencer command is registered onto the bus.
- Arbiter state machine:
  - IDLE: no issue this cycle.
  - HOST: a host issue.
  - SEQ: a sequencer issue.
  - The state is re-evaluated every cycle, with no hold-over, so back-to-back issues from either master are allowed.
  - After an ack, the sequencer must deassert `s_req`, or present a new command, in the next cycle. A `s_req` that is still high is treated as a new command.
- Read tag pipeline: a shift register of depth READ_DELAY, with 2 bits per stage (valid, owner).
  - An issued read inserts {1, owner} at the head.
  - When the tail is valid, `bus_din` is copied to the owner's `rdata` register and that owner's `rvalid` pulses.
  - Both `rdata` registers hold their last value between pulses.
- Writes never enter the tag pipeline.
- `bus_addr` and `bus_wdata` hold their last issued value when idle. `bus_write` and `bus_read` are 0 when idle.
- At most one `bus_write` or `bus_read` is high in any cycle.

## Timing
- Reset (`lb_rst_n` = 0 at a `lb_clk` edge) forces:
  - `bus_addr`, `bus_wdata`, `h_rdata`, `s_rdata` = 0;
  - `bus_write`, `bus_read`, `s_ack`, `h_rvalid`, `s_rvalid` = 0;
  - all tags cleared.
- Reads in flight across a reset are dropped: no `rvalid` is ever produced for them.
- Host issue latency: `h_strobe` in cycle N gives the bus strobe in cycle N+1.
- Host read return: `h_rvalid` in cycle N+1+READ_DELAY+1, because `bus_din` is registered.
- Sequencer issue: `s_req` high in cycle N with the host idle gives `s_ack` in cycle N and the bus strobe in cycle N+1.
- Sequencer read return: `s_rvalid` in cycle N+READ_DELAY+2.
- Simultaneous `h_strobe` and `s_req`: the host issues and the sequencer waits, with `s_ack` = 0 and its command held.
- A pulse on `h_strobe` with `h_write` = 0 is a read. With `h_write` = 1 it is a write.

## Configuration
- `LB_ARB_STARVE_CNT_EN` defined:
  - `s_starve_cnt` increments every cycle that `s_req` is high and `s_ack` is low.
  - It saturates at all-ones.
  - It clears on reset. It is not cleared by ack.
- `LB_ARB_STARVE_CNT_EN` undefined: `s_starve_cnt` is tied to 0 and the counter logic is absent.

## Test plan
- Host read of 0x010040 with READ_DELAY = 3 and the bus model returning 0xDEADBEEF:
  - `bus_read` is high in cycle 1;
  - `h_rvalid` = 1 with `h_rdata` = 0xDEADBEEF in cycle 5;
  - `s_rvalid` stays 0.
- `h_strobe` and `s_req` (write of 0x12345678 to 0x000010) both high in cycle 0:
  - the host issues in cycle 1;
  - `s_ack` pulses in cycle 1, the first cycle the host is idle;
  - the sequencer write appears on the bus in cycle 2.
- Interleaved reads H, S, H, S on consecutive cycles with distinct `bus_din` values 1, 2, 3, 4:
  - the host receives 1 and 3;
  - the sequencer receives 2 and 4, in order, with no cross-delivery.
- Reset asserted one cycle after a sequencer read issues:
  - no `s_rvalid` occurs;
  - all outputs are 0 on the cycle after reset.
- Host streams `h_strobe` for 20 cycles while `s_req` is held:
  - `s_ack` is 0 throughout;
  - with `LB_ARB_STARVE_CNT_EN`, `s_starve_cnt` = 20 after the stream;
  - `s_ack` pulses on the first idle cycle.
- Random mixed traffic for 10k cycles against a scoreboard:
  - exactly one bus strobe per issue;
  - every read receives exactly one `rvalid` at the correct owner.
